// File: rtl/seq_match_reporter.sv
// Records the bit position of every detector match in a small show-ahead FIFO,
// presented on valid/ready, with a saturating match counter and sticky overflow flag.
module seq_match_reporter #(
  parameter int unsigned POS_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     z,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [POS_W-1:0]         out_pos,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LvlFull = DEPTH[AW:0];
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [POS_W-1:0] r_pos;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic [AW:0]      w_level_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [POS_W-1:0] r_mem [DEPTH];

  logic w_event;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_event = en & z;
  assign w_full  = (r_level == LvlFull);
  assign w_pop   = out_valid & out_ready & ~clr;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign w_push  = w_event & ~clr & (~w_full | w_pop);
  assign w_drop  = w_event & ~clr & w_full & ~w_pop;

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + 1'b1;
      2'b01:   w_level_d = r_level - 1'b1;
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_pos   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (en) begin
        r_pos <= r_pos + 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_d;
      // Dropped records still count as matches.
      if (w_event && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_pos;
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_pos    = out_valid ? r_mem[r_rptr] : '0;
  assign match_cnt  = r_cnt;
  assign overflow   = r_ovf;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_seq_match_reporter.sv
// Directed and randomized checks of seq_match_reporter against a queue-based reference model.
module tb_seq_match_reporter;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       z;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pos;
  logic [7:0] match_cnt;
  logic       overflow;
  logic [2:0] fifo_level;

  int checks;
  int errors;

  // Reference model state
  int m_pos;
  int m_q[$];
  int m_cnt;
  bit m_ovf;

  seq_match_reporter #(
    .POS_W(8),
    .DEPTH(DEPTH),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .z         (z),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .match_cnt (match_cnt),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_q.delete();
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit e, input bit zz, input bit rdy, input bit c);
    bit pop;
    pop = (m_q.size() > 0) && rdy;
    if (c) begin
      model_reset();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (e && zz) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pos);
        else m_ovf = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      if (e) m_pos = (m_pos + 1) % 256;
    end
  endtask

  task automatic check_all();
    chk("valid", out_valid, m_q.size() > 0);
    chk("pos", out_pos, (m_q.size() > 0) ? m_q[0] : 0);
    chk("level", fifo_level, m_q.size());
    chk("cnt", match_cnt, m_cnt);
    chk("ovf", overflow, m_ovf);
  endtask

  task automatic step(input bit e, input bit zz, input bit rdy, input bit c);
    en = e;
    z = zz;
    out_ready = rdy;
    clr = c;
    @(posedge clk);
    model_edge(e, zz, rdy, c);
    #1;
    check_all();
  endtask

  initial begin
    int cnt_en;
    logic [2:0] hist;
    bit x;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en = 1'b0;
    z = 1'b0;
    clr = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #6;
    chk("rst_valid", out_valid, 0);
    chk("rst_pos", out_pos, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_ovf", overflow, 0);
    #2 rst = 1'b0;

    // Single match at index 3, then one pop
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 3, 1'b0, 1'b0);
      if (i == 3) begin
        chk("t1_valid", out_valid, 1);
        chk("t1_pos", out_pos, 3);
        chk("t1_level", fifo_level, 1);
        chk("t1_cnt", match_cnt, 1);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_pop_valid", out_valid, 0);
    chk("t1_pop_pos", out_pos, 0);
    chk("t1_pop_level", fifo_level, 0);

    // Overflow: five events into a depth-4 FIFO
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      step(1'b1, (i >= 2) && (i % 2 == 0), 1'b0, 1'b0);
      if (i == 8) chk("t2_level4", fifo_level, 4);
    end
    chk("t2_ovf", overflow, 1);
    chk("t2_cnt", match_cnt, 5);
    chk("t2_level", fifo_level, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain", out_pos, 2 + 2 * k);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_empty", out_valid, 0);
    chk("t2_ovf_sticky", overflow, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_ovf_clr", overflow, 0);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i <= 4; i++) step(1'b1, i >= 1, 1'b0, 1'b0);
    chk("t3_full", fifo_level, 4);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_ovf", overflow, 0);
    chk("t3_level", fifo_level, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain", out_pos, 2 + k);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("t3_empty", out_valid, 0);

    // en gating and position wrap
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cnt_en = 0;
    while (cnt_en < 300) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, cnt_en == 257, 1'b0, 1'b0);
        cnt_en++;
      end else begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("t4_level", fifo_level, 1);
    chk("t4_wrap_pos", out_pos, 1);
    chk("t4_cnt", match_cnt, 1);

    // Counter saturation, clr with simultaneous event, async reset
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_sat", match_cnt, 255);
    chk("t5_ovf", overflow, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_clr_cnt", match_cnt, 0);
    chk("t5_clr_level", fifo_level, 0);
    chk("t5_clr_valid", out_valid, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_held", fifo_level, 2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_arst_valid", out_valid, 0);
    chk("t5_arst_pos", out_pos, 0);
    chk("t5_arst_level", fifo_level, 0);
    chk("t5_arst_cnt", match_cnt, 0);
    #2 rst = 1'b0;

    // Behavioural 1011 overlapping detector feeding z
    rst = 1'b1;
    #8 rst = 1'b0;
    model_reset();
    hist = 3'b000;
    for (int i = 0; i < 7; i++) begin
      x = (i != 1) && (i != 4);
      step(1'b1, (hist == 3'b101) && x, 1'b0, 1'b0);
      hist = {hist[1:0], x};
    end
    chk("t6_cnt", match_cnt, 2);
    chk("t6_level", fifo_level, 2);
    chk("t6_first", out_pos, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_second", out_pos, 6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1),
           $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
